ofm_pack_writer: RTL and testbench

Write-back stage between the 16-lane 3x3 PE cluster and the inter-stage pipeline BRAM. On each completed window it captures the 16 activated 8-bit channel results. It then serialises them as four 32-bit words, four channels per word, and drives the pipeline BRAM write port with a self-generated, wrapping address. This replaces the external mux select and write address that software currently sequences by hand.

---
 rtl/ofm_pack_pkg.sv | 16 +
 rtl/ofm_byte_clamp.sv | 19 +
 rtl/ofm_pack_writer.sv | 145 ++++++++++++++
 tb/tb_ofm_pack_writer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ofm_pack_pkg.sv
// Shared constants, FSM state codes and the word-packing helper for ofm_pack_writer.
package ofm_pack_pkg;

    localparam int unsigned LANES_PER_WORD = 4;
    localparam int unsigned MAX_CH         = 64;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StDrain = 1'b1;

    // Word widx holds lanes 4*widx..4*widx+3, lowest lane in the least significant byte.
    function automatic logic [31:0] pack_word(input logic [MAX_CH*8-1:0] hold,
                                              input int unsigned         widx);
        return hold[widx*LANES_PER_WORD*8 +: LANES_PER_WORD*8];
    endfunction

endpackage

// File: rtl/ofm_byte_clamp.sv
// Combinational ReLU6-style clamp of one signed int8 lane to [0, MAX_VAL].
module ofm_byte_clamp #(
    parameter logic [7:0] MAX_VAL = 8'd96
) (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    always_comb begin
        if (byte_i[7]) begin
            byte_o = 8'd0;
        end else if (byte_i > MAX_VAL) begin
            byte_o = MAX_VAL;
        end else begin
            byte_o = byte_i;
        end
    end

endmodule

// File: rtl/ofm_pack_writer.sv
// Captures a completed window of channel bytes and streams it to the pipeline BRAM as 32-bit words.
// Define RELU6_CLAMP_EN to clamp every captured byte to [0, RELU6_MAX] at capture.
module ofm_pack_writer
    import ofm_pack_pkg::*;
#(
    parameter int unsigned NUM_CH      = 16,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned FRAME_WORDS = 11664,
    parameter logic [7:0]  RELU6_MAX   = 8'd96
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                valid_in,
    input  logic [NUM_CH*8-1:0] data_in,
    output logic                in_ready,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [31:0]         wr_data,
    output logic                frame_done,
    output logic                overflow
);

    localparam int unsigned NumWords = NUM_CH / LANES_PER_WORD;
    localparam int unsigned WcntW    = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam logic [WcntW-1:0]  WcntLast = WcntW'(NumWords - 1);
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(BASE_ADDR + FRAME_WORDS - 1);

    logic [0:0]          state_q, state_d;
    logic [WcntW-1:0]    wcnt_q, wcnt_d;
    logic [NUM_CH*8-1:0] hold_q, hold_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                frame_done_q, frame_done_d;
    logic                overflow_q, overflow_d;
    logic                in_ready_q, in_ready_d;

    logic [NUM_CH*8-1:0] data_cl;
    logic [MAX_CH*8-1:0] src_ext;
    logic [WcntW-1:0]    widx;
    logic                capture;
    logic                emit;

`ifdef RELU6_CLAMP_EN
    for (genvar c = 0; c < NUM_CH; c++) begin : g_clamp
        ofm_byte_clamp #(
            .MAX_VAL(RELU6_MAX)
        ) u_clamp (
            .byte_i(data_in[c*8 +: 8]),
            .byte_o(data_cl[c*8 +: 8])
        );
    end
`else
    logic unused_relu6_max;
    assign unused_relu6_max = ^RELU6_MAX;
    assign data_cl = data_in;
`endif

    assign capture = valid_in && in_ready_q && !start;
    assign emit    = capture || ((state_q == StDrain) && (wcnt_q != WcntLast));
    assign widx    = capture ? '0 : wcnt_q + WcntW'(1);

    always_comb begin
        src_ext = '0;
        src_ext[NUM_CH*8-1:0] = capture ? data_cl : hold_q;
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        hold_d       = hold_q;
        addr_d       = addr_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;

        if (start) begin
            state_d    = StIdle;
            addr_d     = BaseAddr;
            wr_addr_d  = BaseAddr;
            overflow_d = 1'b0;
        end else begin
            if (valid_in && !in_ready_q) begin
                overflow_d = 1'b1;
            end
            if (capture) begin
                hold_d  = data_cl;
                state_d = StDrain;
            end else if (!emit) begin
                state_d = StIdle;
            end
            // Outputs are registered, so the word shown next cycle is built here.
            if (emit) begin
                wcnt_d       = widx;
                wr_en_d      = 1'b1;
                wr_data_d    = pack_word(src_ext, 32'(widx));
                wr_addr_d    = addr_q;
                frame_done_d = (addr_q == LastAddr);
                addr_d       = (addr_q == LastAddr) ? BaseAddr : addr_q + 1'b1;
            end
        end

        in_ready_d = (state_d == StIdle) || (wcnt_d == WcntLast);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            wcnt_q       <= '0;
            hold_q       <= '0;
            addr_q       <= BaseAddr;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= BaseAddr;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            hold_q       <= hold_d;
            addr_q       <= addr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ofm_pack_writer.sv
// Randomised and directed bench for ofm_pack_writer against a queue-based reference model.
module tb_ofm_pack_writer;

    localparam int NCH = 16;
    localparam int NW  = NCH / 4;
    localparam int FW  = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             valid_in;
    logic [NCH*8-1:0] data_in;
    logic             in_ready;
    logic             wr_en;
    logic [31:0]      wr_addr;
    logic [31:0]      wr_data;
    logic             frame_done;
    logic             overflow;

    always #5 clk = ~clk;

    ofm_pack_writer #(
        .NUM_CH     (NCH),
        .ADDR_W     (32),
        .BASE_ADDR  (0),
        .FRAME_WORDS(FW),
        .RELU6_MAX  (8'd96)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_done(frame_done),
        .overflow  (overflow)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned n_wr;

    // Reference model: words waiting to be written, next address, sticky overflow.
    logic [31:0] pend_q[$];
    int unsigned m_addr;
    bit          m_ovf;
    bit          m_en;
    bit          m_fd;
    logic [31:0] m_wdata;
    logic [31:0] m_waddr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] lane_val(input logic [7:0] b);
`ifdef RELU6_CLAMP_EN
        int s;
        s = (b >= 8'd128) ? int'(b) - 256 : int'(b);
        if (s < 0) return 8'd0;
        if (s > 96) return 8'd96;
        return b;
`else
        return b;
`endif
    endfunction

    function automatic logic [NCH*8-1:0] rand_data();
        logic [NCH*8-1:0] d;
        for (int i = 0; i < NCH / 4; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        pend_q.delete();
        m_addr  = 0;
        m_ovf   = 0;
        m_en    = 0;
        m_fd    = 0;
        m_waddr = 0;
        m_wdata = 0;
    endtask

    task automatic model_step(input bit v, input logic [NCH*8-1:0] d, input bit s);
        logic [31:0] word;
        m_fd = 0;
        if (s) begin
            pend_q.delete();
            m_addr = 0;
            m_ovf  = 0;
            m_en   = 0;
            return;
        end
        if (v) begin
            if (pend_q.size() == 0) begin
                for (int w = 0; w < NW; w++) begin
                    word = 0;
                    for (int k = 0; k < 4; k++)
                        word = word | (32'(lane_val(d[(4*w+k)*8 +: 8])) << (8*k));
                    pend_q.push_back(word);
                end
            end else begin
                m_ovf = 1;
            end
        end
        if (pend_q.size() > 0) begin
            m_en    = 1;
            m_wdata = pend_q.pop_front();
            m_waddr = m_addr;
            m_fd    = (m_addr == FW - 1);
            m_addr  = (m_addr + 1) % FW;
        end else begin
            m_en = 0;
        end
    endtask

    task automatic check_outputs();
        check_eq("wr_en", 32'(wr_en), 32'(m_en));
        check_eq("in_ready", 32'(in_ready), 32'(pend_q.size() == 0));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("frame_done", 32'(frame_done), 32'(m_fd));
        if (m_en) begin
            check_eq("wr_addr", wr_addr, m_waddr);
            check_eq("wr_data", wr_data, m_wdata);
        end
    endtask

    task automatic step(input bit v, input logic [NCH*8-1:0] d, input bit s);
        valid_in = v;
        data_in  = d;
        start    = s;
        @(posedge clk);
        #1;
        model_step(v, d, s);
        check_outputs();
        n_wr += int'(wr_en);
        valid_in = 1'b0;
        start    = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        valid_in = 1'b0;
        start    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_eq("rst_wr_en", 32'(wr_en), 32'd0);
        check_eq("rst_wr_addr", wr_addr, 32'd0);
        check_eq("rst_wr_data", wr_data, 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        n_wr = 0;
    endtask

    logic [31:0]      t1_exp [NW];
    logic [NCH*8-1:0] d;

    initial begin
        t1_exp   = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        data_in  = '0;
        valid_in = 1'b0;
        start    = 1'b0;
        reset    = 1'b1;
        n_wr     = 0;

        // Single window, ch c = c+1.
        do_reset();
        for (int c = 0; c < NCH; c++) d[c*8 +: 8] = 8'(c + 1);
        step(1, d, 0);
        for (int w = 0; w < NW; w++) begin
            check_eq("t1_word", wr_data, t1_exp[w]);
            check_eq("t1_addr", wr_addr, 32'(w));
            step(0, '0, 0);
        end
        check_eq("t1_overflow", 32'(overflow), 32'd0);

        // Three back-to-back windows across the frame wrap.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, rand_data(), 0);
            repeat (NW - 1) step(0, '0, 0);
        end
        step(0, '0, 0);
        check_eq("b2b_writes", 32'(n_wr), 32'(3 * NW));

        // Second window during drain is dropped.
        do_reset();
        step(1, rand_data(), 0);
        step(0, '0, 0);
        step(1, rand_data(), 0);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        repeat (4) step(0, '0, 0);
        check_eq("ovf_held", 32'(overflow), 32'd1);
        check_eq("ovf_writes", 32'(n_wr), 32'(NW));

        // start with valid_in on the second drain word.
        step(1, rand_data(), 0);
        step(0, '0, 0);
        step(1, rand_data(), 1);
        check_eq("start_wr_en", 32'(wr_en), 32'd0);
        check_eq("start_ovf", 32'(overflow), 32'd0);
        check_eq("start_ready", 32'(in_ready), 32'd1);
        step(0, '0, 0);
        step(1, rand_data(), 0);
        check_eq("start_addr", wr_addr, 32'd0);
        step(0, '0, 0);

        // Reset mid-drain loses remaining words.
        do_reset();
        step(1, rand_data(), 0);
        step(0, '0, 0);
        do_reset();

        // Clamp boundary lanes.
        d = rand_data();
        d[31:0] = 32'h307FFF80;
        step(1, d, 0);
`ifdef RELU6_CLAMP_EN
        check_eq("clamp_word0", wr_data, 32'h30600000);
`else
        check_eq("clamp_word0", wr_data, 32'h307FFF80);
`endif
        repeat (NW) step(0, '0, 0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 35), rand_data(), ($urandom_range(0, 99) < 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
